// File: rtl/pulse_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pulse_cmd_decoder
// Purpose  : Parses framed byte commands from the UART receiver (opcode plus
//            big-endian payload), atomically updates one pulse parameter
//            register per frame, and returns an ACK (0x06) or NAK (0x15)
//            byte to the UART transmitter. Holds the power-on defaults of
//            every pulse parameter.
// Ports    : clk, resetn          - clock, synchronous active-low reset
//            rx_data_i/rx_valid_i - received byte and its one-cycle strobe
//            tx_data_o/tx_valid_o - response byte, held until tx_ready_i
//            tx_ready_i           - transmitter accepts the response byte
//            period_o .. post_att_o - pulse parameter registers
//            param_update_o       - one-cycle strobe on any register write
//            busy_o               - high whenever a frame/response is active
// Revision : 1.0 - initial release
// ============================================================================
module pulse_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter int unsigned DEF_PERIOD     = 201000,
  parameter int unsigned DEF_P1WIDTH    = 30,
  parameter int unsigned DEF_P2WIDTH    = 30,
  parameter int unsigned DEF_DELAY      = 200,
  parameter int unsigned DEF_BLOCK_ON   = 50,
  parameter int unsigned DEF_BLOCK_OFF  = 100,
  parameter int unsigned DEF_CPMG       = 1,
  parameter int unsigned DEF_POST_ATT   = 127
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] period_o,
  output logic [31:0] p1width_o,
  output logic [31:0] delay_o,
  output logic [31:0] p2width_o,
  output logic        pump_o,
  output logic        block_o,
  output logic [7:0]  pulse_block_o,
  output logic [15:0] pulse_block_off_o,
  output logic [7:0]  cpmg_o,
  output logic [6:0]  pre_att_o,
  output logic [6:0]  post_att_o,
  output logic        param_update_o,
  output logic        busy_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] c_ACK        = 8'h06;
  localparam logic [7:0] c_NAK        = 8'h15;
  localparam logic [7:0] c_OP_RESTORE = 8'h0C;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_COMMIT  = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state_q;
  logic [7:0]       opcode_q;
  logic [2:0]       cnt_q;
  logic [31:0]      shift_q;
  logic [31:0]      shift_d;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             param_update_q;

  logic [31:0] period_q, p1width_q, delay_q, p2width_q;
  logic        pump_q, block_q;
  logic [7:0]  pulse_block_q, cpmg_q;
  logic [15:0] pulse_block_off_q;
  logic [6:0]  pre_att_q, post_att_q;

  logic w_commit;
  logic w_restore;

  // Known opcodes are 0x01..0x0C; anything else is NAKed.
  function automatic logic op_known(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h0C);
  endfunction

  function automatic logic [2:0] payload_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h03, 8'h04: return 3'd4;
      8'h08:                      return 3'd2;
      8'h0C:                      return 3'd0;
      default:                    return 3'd1;
    endcase
  endfunction

  // Payload arrives MSB first; older bytes migrate toward the top.
  assign shift_d = {shift_q[23:0], rx_data_i};

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      opcode_q       <= 8'h00;
      cnt_q          <= 3'd0;
      shift_q        <= 32'd0;
      tmo_q          <= '0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      param_update_q <= 1'b0;
    end else begin
      param_update_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            if (op_known(rx_data_i)) begin
              opcode_q <= rx_data_i;
              cnt_q    <= payload_len(rx_data_i);
              shift_q  <= 32'd0;
              tmo_q    <= '0;
              state_q  <= (payload_len(rx_data_i) == 3'd0) ? S_COMMIT : S_PAYLOAD;
            end else begin
              tx_data_q <= c_NAK;
              state_q   <= S_RESP;
            end
          end
        end
        S_PAYLOAD: begin
          // A byte arriving on the expiry cycle takes priority over the abort.
          if (rx_valid_i) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q - 3'd1;
            tmo_q   <= '0;
            if (cnt_q == 3'd1) begin
              state_q <= S_COMMIT;
            end
          end else if (tmo_q == c_TMO_LAST) begin
            tx_data_q <= c_NAK;
            state_q   <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_COMMIT: begin
          param_update_q <= 1'b1;
          tx_data_q      <= c_ACK;
          state_q        <= S_RESP;
        end
        S_RESP: begin
          // tx_valid rises one cycle after entering RESP, so the register
          // write is visible a cycle before the response byte is offered.
          if (tx_valid_q && tx_ready_i) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            tx_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Parameter register file
  // --------------------------------------------------------------------------
  assign w_commit  = (state_q == S_COMMIT);
  assign w_restore = w_commit && (opcode_q == c_OP_RESTORE);

  always_ff @(posedge clk) begin
    if (!resetn || w_restore) begin
      period_q          <= 32'(DEF_PERIOD);
      p1width_q         <= 32'(DEF_P1WIDTH);
      delay_q           <= 32'(DEF_DELAY);
      p2width_q         <= 32'(DEF_P2WIDTH);
      pump_q            <= 1'b1;
      block_q           <= 1'b1;
      pulse_block_q     <= 8'(DEF_BLOCK_ON);
      pulse_block_off_q <= 16'(DEF_BLOCK_OFF);
      cpmg_q            <= 8'(DEF_CPMG);
      pre_att_q         <= 7'd0;
      post_att_q        <= 7'(DEF_POST_ATT);
    end else if (w_commit) begin
      case (opcode_q)
        8'h01:   period_q          <= shift_q;
        8'h02:   p1width_q         <= shift_q;
        8'h03:   delay_q           <= shift_q;
        8'h04:   p2width_q         <= shift_q;
        8'h05:   pump_q            <= shift_q[0];
        8'h06:   block_q           <= shift_q[0];
        8'h07:   pulse_block_q     <= shift_q[7:0];
        8'h08:   pulse_block_off_q <= shift_q[15:0];
        8'h09:   cpmg_q            <= shift_q[7:0];
        8'h0A:   pre_att_q         <= shift_q[6:0];
        8'h0B:   post_att_q        <= shift_q[6:0];
        default: ;
      endcase
    end
  end

  assign tx_data_o         = tx_data_q;
  assign tx_valid_o        = tx_valid_q;
  assign param_update_o    = param_update_q;
  assign busy_o            = (state_q != S_IDLE);
  assign period_o          = period_q;
  assign p1width_o         = p1width_q;
  assign delay_o           = delay_q;
  assign p2width_o         = p2width_q;
  assign pump_o            = pump_q;
  assign block_o           = block_q;
  assign pulse_block_o     = pulse_block_q;
  assign pulse_block_off_o = pulse_block_off_q;
  assign cpmg_o            = cpmg_q;
  assign pre_att_o         = pre_att_q;
  assign post_att_o        = post_att_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_cmd_decoder
// Purpose  : Self-checking bench for pulse_cmd_decoder. A frame-level model
//            (byte queue, gap counter, response stage) predicts every output
//            each cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_cmd_decoder;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] period, p1width, delay, p2width;
  logic        pump, block;
  logic [7:0]  pulse_block, cpmg;
  logic [15:0] pulse_block_off;
  logic [6:0]  pre_att, post_att;
  logic        param_update, busy;

  always #5 clk = ~clk;

  pulse_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .period_o(period), .p1width_o(p1width), .delay_o(delay), .p2width_o(p2width),
    .pump_o(pump), .block_o(block), .pulse_block_o(pulse_block),
    .pulse_block_off_o(pulse_block_off), .cpmg_o(cpmg),
    .pre_att_o(pre_att), .post_att_o(post_att),
    .param_update_o(param_update), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Frame-level model
  // --------------------------------------------------------------------------
  logic [31:0] e_period, e_p1, e_delay, e_p2;
  logic        e_pump, e_block, e_pu;
  logic [7:0]  e_pb, e_cpmg, e_txd;
  logic [15:0] e_pbo;
  logic [6:0]  e_pre, e_post;
  logic [7:0]  q[$];
  logic [7:0]  m_op;
  int          need, gap;
  int          stage = 0;          // 0 none, 1 response armed, 2 response offered
  bit          collecting = 0, commit_pending = 0, started = 0;

  function automatic int len_of(input logic [7:0] o);
    if (o >= 8'h01 && o <= 8'h04) return 4;
    if (o == 8'h08) return 2;
    if (o == 8'h0C) return 0;
    if (o >= 8'h05 && o <= 8'h0B) return 1;
    return -1;
  endfunction

  task automatic model_defaults();
    e_period = 201000; e_p1 = 30; e_p2 = 30; e_delay = 200;
    e_pb = 50; e_pbo = 100; e_cpmg = 1; e_post = 127;
    e_pump = 1'b1; e_block = 1'b1; e_pre = 7'd0;
  endtask

  task automatic model_commit();
    logic [31:0] v;
    v = 32'd0;
    foreach (q[i]) v = (v << 8) | 32'(q[i]);
    case (m_op)
      8'h01: e_period = v;
      8'h02: e_p1     = v;
      8'h03: e_delay  = v;
      8'h04: e_p2     = v;
      8'h05: e_pump   = v[0];
      8'h06: e_block  = v[0];
      8'h07: e_pb     = v[7:0];
      8'h08: e_pbo    = v[15:0];
      8'h09: e_cpmg   = v[7:0];
      8'h0A: e_pre    = v[6:0];
      8'h0B: e_post   = v[6:0];
      default: model_defaults();
    endcase
  endtask

  always @(posedge clk) begin
    e_pu = 1'b0;
    if (!resetn) begin
      model_defaults();
      e_txd = 8'h00; stage = 0; collecting = 0; commit_pending = 0;
      q.delete(); started = 1;
    end else if (stage != 0) begin
      if (stage == 2) begin
        if (tx_ready) stage = 0;
      end else begin
        stage = 2;
      end
    end else if (commit_pending) begin
      commit_pending = 0;
      model_commit();
      e_pu = 1'b1; e_txd = 8'h06; stage = 1;
    end else if (collecting) begin
      if (rx_valid) begin
        q.push_back(rx_data); gap = 0;
        if (q.size() == need) begin collecting = 0; commit_pending = 1; end
      end else begin
        gap++;
        if (gap == TMO) begin collecting = 0; e_txd = 8'h15; stage = 1; end
      end
    end else if (rx_valid) begin
      need = len_of(rx_data);
      if (need < 0) begin
        e_txd = 8'h15; stage = 1;
      end else begin
        m_op = rx_data; q.delete(); gap = 0;
        if (need == 0) commit_pending = 1; else collecting = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      check("period", period, e_period);
      check("p1width", p1width, e_p1);
      check("delay", delay, e_delay);
      check("p2width", p2width, e_p2);
      check("pump", 32'(pump), 32'(e_pump));
      check("block", 32'(block), 32'(e_block));
      check("pulse_block", 32'(pulse_block), 32'(e_pb));
      check("pulse_block_off", 32'(pulse_block_off), 32'(e_pbo));
      check("cpmg", 32'(cpmg), 32'(e_cpmg));
      check("pre_att", 32'(pre_att), 32'(e_pre));
      check("post_att", 32'(post_att), 32'(e_post));
      check("param_update", 32'(param_update), 32'(e_pu));
      check("tx_data", 32'(tx_data), 32'(e_txd));
      check("tx_valid", 32'(tx_valid), 32'(stage == 2));
      check("busy", 32'(busy), 32'(collecting || commit_pending || stage != 0));
    end
  end

  // Response and update monitors used by the literal checks.
  logic [7:0] last_tx = 8'h00;
  int         pu_cnt = 0;
  always @(negedge clk) begin
    if (tx_valid) last_tx = tx_data;
    if (param_update) pu_cnt++;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && !tx_valid) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: DUT still busy after 60 cycles, expected idle", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pu0;
    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    idle(2);
    check("rst period", period, 32'd201000);
    check("rst p1width", p1width, 32'd30);
    check("rst delay", delay, 32'd200);
    check("rst pump", 32'(pump), 32'd1);
    check("rst cpmg", 32'(cpmg), 32'd1);
    check("rst pre_att", 32'(pre_att), 32'd0);
    check("rst post_att", 32'(post_att), 32'd127);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    resetn = 1'b1;
    idle(2);

    // Period write with exact latency pinning.
    pu0 = pu_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h27);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h10;
    @(negedge clk); rx_valid = 1'b0;             // COMMIT cycle
    @(negedge clk);
    check("lat period", period, 32'd10000);
    check("lat param_update", 32'(param_update), 32'd1);
    @(negedge clk);
    check("lat tx_valid", 32'(tx_valid), 32'd1);
    check("lat tx_data", 32'(tx_data), 32'h06);
    wait_idle("period frame");
    check("period pu count", 32'(pu_cnt - pu0), 32'd1);
    check("period p1width kept", p1width, 32'd30);

    send_byte(8'h0A); send_byte(8'hFF);
    wait_idle("pre_att frame");
    check("pre_att", 32'(pre_att), 32'h7F);
    check("pre_att ack", 32'(last_tx), 32'h06);

    send_byte(8'h08); send_byte(8'h12); send_byte(8'h34);
    wait_idle("pbo frame");
    check("pulse_block_off", 32'(pulse_block_off), 32'h1234);
    check("pbo ack", 32'(last_tx), 32'h06);

    // Unknown opcode, response held with tx_ready low; stray byte is dropped.
    pu0 = pu_cnt;
    tx_ready = 1'b0;
    send_byte(8'h55);
    idle(3);
    send_byte(8'h01);
    idle(7);
    check("hold tx_valid", 32'(tx_valid), 32'd1);
    check("hold tx_data", 32'(tx_data), 32'h15);
    tx_ready = 1'b1;
    wait_idle("nak frame");
    check("nak busy", 32'(busy), 32'd0);
    check("nak no update", 32'(pu_cnt - pu0), 32'd0);

    // Payload timeout aborts the frame.
    pu0 = pu_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    idle(TMO + 20);
    wait_idle("timeout frame");
    check("timeout nak", 32'(last_tx), 32'h15);
    check("timeout p1width", p1width, 32'd30);
    check("timeout no update", 32'(pu_cnt - pu0), 32'd0);

    // Byte lands exactly on the expiry cycle: gap of TMO cycles between samples.
    pu0 = pu_cnt;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    idle(TMO - 2);
    send_byte(8'h00); send_byte(8'h1E);
    wait_idle("expiry frame");
    check("expiry ack", 32'(last_tx), 32'h06);
    check("expiry update", 32'(pu_cnt - pu0), 32'd1);
    check("expiry p1width", p1width, 32'd30);

    // Restore defaults.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h13); send_byte(8'h88);
    wait_idle("period 5000");
    check("period 5000", period, 32'd5000);
    send_byte(8'h0C);
    wait_idle("restore");
    check("restore period", period, 32'd201000);
    check("restore pre_att", 32'(pre_att), 32'd0);
    check("restore pbo", 32'(pulse_block_off), 32'd100);
    check("restore ack", 32'(last_tx), 32'h06);

    // Reset in the middle of a delay frame.
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    wait_idle("delay 256");
    check("delay 256", delay, 32'd256);
    send_byte(8'h03); send_byte(8'h00);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle(5);
    check("midrst delay", delay, 32'd200);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst tx_valid", 32'(tx_valid), 32'd0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pulse_cmd_decoder.md
Name: pulse_cmd_decoder

Overview:
Byte-level command decoder between the UART receive/transmit stage and the pulse parameter registers that drive `pulses`. It parses framed commands (opcode plus big-endian payload) from the serial link. On frame completion it updates one parameter register atomically and returns an ACK or NAK byte to the UART transmitter. It holds the power-on defaults and replaces the hard-wired initialisation block in the top level.

Parameters:
TIMEOUT_CYCLES, 1200000, max clk cycles between payload bytes before a frame is aborted (100 ms at 12 MHz)
DEF_PERIOD, 201000, reset value of period
DEF_P1WIDTH, 30, reset value of p1width
DEF_P2WIDTH, 30, reset value of p2width
DEF_DELAY, 200, reset value of delay
DEF_BLOCK_ON, 50, reset value of pulse_block
DEF_BLOCK_OFF, 100, reset value of pulse_block_off
DEF_CPMG, 1, reset value of cpmg
DEF_POST_ATT, 127, reset value of post_att

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  response byte
tx_valid  out  1  response byte pending
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
period / p1width / delay / p2width  out  32 each  pulse timing registers
pump, block  out  1 each  enables
pulse_block  out  8  block-on count
pulse_block_off  out  16  block-off count
cpmg  out  8  refocusing pulse count
pre_att, post_att  out  7 each  attenuator codes
param_update  out  1  one-cycle strobe on any register write
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (resetn low at a clk edge) sets outputs to the following values:
  - period, p1width, p2width, delay, pulse_block, pulse_block_off, cpmg, post_att = their DEF_ values.
  - pump = 1, block = 1, pre_att = 0.
  - tx_valid = 0, tx_data = 0, param_update = 0, busy = 0.
  - State returns to IDLE; any partial payload is discarded.
- Opcode table (opcode: target, payload bytes):
  - 0x01 period 4; 0x02 p1width 4; 0x03 delay 4; 0x04 p2width 4.
  - 0x05 pump 1 (bit0); 0x06 block 1 (bit0); 0x07 pulse_block 1; 0x08 pulse_block_off 2; 0x09 cpmg 1.
  - 0x0A pre_att 1 (bits6:0); 0x0B post_att 1 (bits6:0).
  - 0x0C restore all defaults, 0 payload bytes.
- Payload is MSB first and accumulates in a 32-bit shift register. Only the low bits of the target width are written; the remaining bits are ignored.
- FSM states: IDLE, PAYLOAD, COMMIT, RESP.
- IDLE:
  - rx_valid with a known opcode: latch opcode, load byte counter with payload length, go to PAYLOAD. If length is 0, go directly to COMMIT.
  - rx_valid with an unknown opcode: tx_data=0x15 (NAK), go to RESP.
- PAYLOAD:
  - Each rx_valid shifts in a byte, decrements the counter, and clears the timeout counter.
  - On the last byte, go to COMMIT.
  - If the timeout counter reaches TIMEOUT_CYCLES with no byte: discard the frame, tx_data=0x15, go to RESP.
  - If rx_valid and timeout expiry occur in the same cycle, the byte wins.
- COMMIT (exactly 1 cycle): write the target register(s), assert param_update=1, tx_data=0x06 (ACK), go to RESP.
- Latency: last payload byte accepted at cycle N → register value and param_update visible at N+1 → tx_valid=1 at N+2.
- RESP:
  - tx_valid=1; tx_data held stable until tx_ready.
  - On handshake, tx_valid drops the next cycle and the FSM returns to IDLE.
- rx_valid bytes arriving in COMMIT or RESP are dropped. No queueing.
- Registers not addressed by a frame never change. Aborted and NAKed frames never assert param_update.
- Reset mid-frame or mid-RESP: registers revert to defaults, and any pending response is cancelled (tx_valid=0 next cycle).

Test Plan:
- Reset with resetn=0 for 2 cycles → period=201000, p1width=30, delay=200, pump=1, cpmg=1, pre_att=0, post_att=127, tx_valid=0.
- Send bytes 01 00 00 27 10, tx_ready=1 → period=10000 one cycle after the last byte; param_update pulses once; tx_data=0x06; no other register changes.
- Send 0A FF → pre_att=0x7F; send 08 12 34 → pulse_block_off=0x1234; each frame returns ACK 0x06.
- Send opcode 0x55 → NAK 0x15, busy returns to 0, no param_update. Then hold tx_ready=0 for 10 cycles → tx_valid and tx_data stay constant until tx_ready rises.
- Send 02 00 00, then idle TIMEOUT_CYCLES (bench override 100) → NAK 0x15, p1width unchanged at 30. Repeat with the third byte arriving exactly on the expiry cycle → frame continues; completing it with 1E → p1width=30 write plus ACK.
- Program period=5000, send 0C → all registers back to defaults with ACK. Separately, assert resetn=0 after 03 00 → delay=200, state IDLE, no response byte emitted.
